top_atanh_f2fp16: RTL and testbench
===================================

// Module: top_atanh_f2fp16
// PURPOSE
//  Inverse activation: fp32 in, atanh(x) out as 16-bit float (1/8/7, bias 127).
//  Counterpart to the tanh path (fp16 -> fp32); maps activations back to pre-activation domain.
//  Four-stage pipeline around a synchronous-read LUT; valid tag travels with data; enable stalls all.
// PARAMETERS
//  ADDR_WIDTH   10             LUT address bits; |x| in [0,1) quantised to 2^-10 steps
//  DATA_WIDTH   12             LUT word, unsigned fixed 2.10 (max 3.999)
//  LUT_FILE     "atanh_4.hex"  LUT init: entry a = min(4095, round(atanh(a/1024)*1024))
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous reset, active low
//  enable       in   1   1: pipeline advances; 0: every register holds (LUT read disabled)
//  valid_in     in   1   num_entrada holds a sample this cycle
//  num_entrada  in   32  fp32 operand
//  valid_out    out  1   num_salida holds a result
//  num_salida   out  16  atanh result, 1/8/7 float
// BEHAVIOUR
//  One clock, rst_n async active-low. Reset: valid_out=0, num_salida=16'h0000, all stage valids/flags 0.
//  Reset mid-operation drops all in-flight samples; LUT RAM has no reset (irrelevant: valids cleared).
//  Stage regs update only when enable=1; enable=0 freezes data AND valid (no bubble insertion, no loss).
//  Latency: sample accepted at edge N (enable=1) appears at edge N+3 (four register stages; in-reg is 1st).
//  Throughput 1/cycle; valid_in=0 produces valid_out=0 bubble at the same offset; num_salida held otherwise.
//  S1 in-reg: capture {valid_in, num_entrada}.
//  S2 classify (comb from S1, registered with LUT read): s=bit31, e=bits30:23, m=bits22:0.
//   NAN : e=255 & m!=0            -> result 16'h7FC0 (sign ignored)
//   SAT : e>=127 (|x|>=1, incl inf)-> {s,8'hFF,7'h00} (signed infinity)
//   TINY: e<117 (|x|<2^-10, incl zero/denormal) -> pass-through {s,e,m[22:16]} truncated; denormals -> {s,15'h0}
//   LUT : 117<=e<=126 -> addr = {1'b1,m[22:14]} >> (126-e), truncating; addr in [1,1023]
//  S3 LUT data valid; convert q (2.10) to float: q=0 -> 16'h0000 with sign s;
//   p = index of leading one (0..11); exp = 127+p-10; mant = next 7 bits below leading one, zero-filled, truncated.
//   Result = {s,exp,mant}; non-LUT classes take their pre-formed word (carried as flags + 16-bit bypass).
//  S4 out-reg: num_salida, valid_out.
//  No rounding anywhere (truncation only); negative input mirrors positive (odd function).
// STRUCTURE
//  Package atanh_pkg: BF16_BIAS=127, BF16_INF=16'h7F80, BF16_QNAN=16'h7FC0, class enum {NAN,SAT,TINY,LUT}.
//  Reuse memoria_single_port (DATA_WIDTH, ADDR_WIDTH, LUT_FILE) as the S2 LUT, enable tied to enable.
//  One new sub-module: fixed_to_bf16 (comb, DATA_WIDTH-bit unsigned + radix 10 -> 15-bit magnitude).
// TESTING
//  0x3F000000 (0.5): addr 512, q=562 -> 0x3F0C on valid_out after 4th edge.
//  0xBF000000 (-0.5) -> 0xBF0C; 0x3F800000 (1.0) -> 0x7F80; 0xFF800000 (-inf) -> 0xFF80.
//  0x7FC00000 (NaN) -> 0x7FC0; 0x39800000 (2^-12) -> 0x3980; 0x00000001 (denorm) -> 0x0000.
//  Back-to-back 8 samples, enable=1: 8 consecutive valid_out, in order, latency 4 each.
//  Stream with enable low 3 cycles mid-flight: outputs/valids frozen, no sample lost or duplicated.
//  rst_n asserted with 3 samples in flight: valid_out=0, num_salida=0 immediately (async), none emerge after.

Source files
------------

// File: rtl/atanh_pkg.sv
// ----------------------------------------------------------------------------
// atanh_pkg
//   Shared constants, types and helpers for the fp32 -> 1/8/7 atanh path.
//   - 1/8/7 float constants (bias, infinity, quiet NaN)
//   - operand class enum used to steer the result mux
//   - atanh_lut_entry(): elaboration-time generator for the LUT contents
//     (entry a = min(2^dw-1, round(atanh(a/2^aw) * 2^frac)))
// ----------------------------------------------------------------------------
package atanh_pkg;

    localparam int          BF16_BIAS = 127;
    localparam logic [15:0] BF16_INF  = 16'h7F80;
    localparam logic [15:0] BF16_QNAN = 16'h7FC0;

    // Radix point of the LUT word (unsigned 2.10).
    localparam int          LUT_FRAC  = 10;

    typedef enum logic [1:0] {
        CLS_NAN  = 2'd0,
        CLS_SAT  = 2'd1,
        CLS_TINY = 2'd2,
        CLS_LUT  = 2'd3
    } atanh_class_e;

    // atanh(x) = 0.5 * ln((1+x)/(1-x)), evaluated with integers only so the
    // table can be built as a constant: log2 of the ratio by repeated
    // squaring (24 fraction bits), then scaled by ln2 in Q30.
    function automatic logic [31:0] atanh_lut_entry(input int a, input int aw,
                                                    input int frac, input int dw);
        logic [63:0] num;
        logic [63:0] den;
        logic [63:0] y;
        logic [63:0] lg;
        logic [63:0] prod;
        logic [63:0] max_v;
        int          k;
        num   = (64'd1 << aw) + 64'(a);
        den   = (64'd1 << aw) - 64'(a);
        k     = 0;
        max_v = (64'd1 << dw) - 64'd1;
        // Normalise the ratio into [1,2); k is the integer part of log2.
        while (num >= (den << 1)) begin
            den = den << 1;
            k   = k + 1;
        end
        y  = (num << 30) / den;
        lg = 64'(k) << 24;
        for (int i = 23; i >= 0; i--) begin
            y = (y * y) >> 30;
            if (y >= (64'd1 << 31)) begin
                y     = y >> 1;
                lg[i] = 1'b1;
            end
        end
        // lg (Q24) * ln2 (Q30) = ln(ratio) in Q54; want ln/2 * 2^frac, rounded.
        prod = lg * 64'd744261118;
        prod = (prod + (64'd1 << (54 - frac))) >> (55 - frac);
        if (a == 0) begin
            prod = 64'd0;
        end
        if (prod > max_v) begin
            prod = max_v;
        end
        return 32'(prod);
    endfunction

endpackage

// File: rtl/fixed_to_bf16.sv
// ----------------------------------------------------------------------------
// fixed_to_bf16
//   Combinational conversion of an unsigned fixed-point value (FRAC_BITS
//   fraction bits) to the 15-bit magnitude {exp[7:0], mant[6:0]} of a 1/8/7
//   float. Mantissa is truncated; zero maps to an all-zero magnitude.
// Ports
//   q    in  DATA_WIDTH  unsigned fixed-point input
//   mag  out 15          {exponent, mantissa}
// ----------------------------------------------------------------------------
module fixed_to_bf16
    import atanh_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int FRAC_BITS  = 10
) (
    input  logic [DATA_WIDTH-1:0] q,
    output logic [14:0]           mag
);

    localparam int LW = $clog2(DATA_WIDTH);

    logic [LW-1:0]         lead_s;
    logic [DATA_WIDTH-1:0] norm_s;
    logic [6:0]            mant_s;
    logic [7:0]            exp_s;

    // Leading-one search, shift it to the MSB, take the 7 bits under it.
    always_comb begin
        lead_s = {LW{1'b0}};
        for (int i = 0; i < DATA_WIDTH; i++) begin
            lead_s = q[i] ? LW'(i) : lead_s;
        end
        norm_s = q << (LW'(DATA_WIDTH - 1) - lead_s);
        mant_s = 7'(norm_s >> (DATA_WIDTH - 8));
        exp_s  = 8'(BF16_BIAS - FRAC_BITS) + 8'(lead_s);
        if (q == {DATA_WIDTH{1'b0}}) begin
            mag = 15'h0000;
        end else begin
            mag = {exp_s, mant_s};
        end
    end

endmodule

// File: rtl/memoria_single_port.sv
// ----------------------------------------------------------------------------
// memoria_single_port
//   Single-port synchronous-read table holding the atanh LUT. Contents are
//   generated at elaboration from atanh_lut_entry(). No reset on the storage
//   or the read register: downstream valid tags make stale data harmless.
// Ports
//   clk     in  1           clock, rising edge
//   enable  in  1           1: read register loads table[addr]; 0: holds
//   addr    in  ADDR_WIDTH  read address
//   q       out DATA_WIDTH  registered read data (unsigned fixed, FRAC_BITS)
// ----------------------------------------------------------------------------
module memoria_single_port
    import atanh_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 10,
    parameter int FRAC_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rom_s [DEPTH];
    logic [DATA_WIDTH-1:0] q_r;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        localparam logic [31:0] ENTRY = atanh_lut_entry(gi, ADDR_WIDTH, FRAC_BITS, DATA_WIDTH);
        assign rom_s[gi] = ENTRY[DATA_WIDTH-1:0];
    end

    // Synchronous read, frozen together with the rest of the pipeline.
    always_ff @(posedge clk) begin
        if (enable) begin
            q_r <= rom_s[addr];
        end
    end

    assign q = q_r;

endmodule

// File: rtl/top_atanh_f2fp16.sv
// ----------------------------------------------------------------------------
// top_atanh_f2fp16
//   atanh(x) for an fp32 operand, result as a 1/8/7 float (bias 127).
//   Four register stages: S1 input capture, S2 classification + LUT read,
//   S3 fixed->float conversion and result select, S4 output register.
//   A sample captured at edge N is presented at edge N+3. enable=0 freezes
//   every stage (data and valid tags, LUT read included).
// Ports
//   clk          in  1   clock, rising edge
//   rst_n        in  1   asynchronous reset, active low
//   enable       in  1   1: pipeline advances; 0: all registers hold
//   valid_in     in  1   num_entrada carries a sample
//   num_entrada  in  32  fp32 operand
//   valid_out    out 1   num_salida carries a result
//   num_salida   out 16  atanh result, 1/8/7 float (held across bubbles)
// ----------------------------------------------------------------------------
module top_atanh_f2fp16
    import atanh_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        valid_in,
    input  logic [31:0] num_entrada,
    output logic        valid_out,
    output logic [15:0] num_salida
);

    // |x| < 2^-ADDR_WIDTH falls below the first LUT step.
    localparam logic [7:0] LUT_MIN_EXP = 8'(BF16_BIAS - ADDR_WIDTH);
    localparam logic [7:0] LUT_TOP_EXP = 8'(BF16_BIAS - 1);
    localparam logic [7:0] ONE_EXP     = 8'(BF16_BIAS);

    // S1
    logic                  s1_valid_r;
    logic [31:0]           s1_num_r;
    // classify (comb from S1)
    logic                  sign_s;
    logic [7:0]            exp_s;
    logic [22:0]           man_s;
    atanh_class_e          cls_s;
    logic [15:0]           bypass_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    // S2
    logic                  s2_valid_r;
    logic                  s2_sign_r;
    atanh_class_e          s2_cls_r;
    logic [15:0]           s2_bypass_r;
    logic [DATA_WIDTH-1:0] lut_q_s;
    // convert (comb from S2)
    logic [14:0]           mag_s;
    logic [15:0]           result_s;
    // S3
    logic                  s3_valid_r;
    logic [15:0]           s3_result_r;
    // S4
    logic                  valid_out_r;
    logic [15:0]           num_salida_r;

    // S1: capture the incoming sample and its valid tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_num_r   <= 32'h0000_0000;
        end else if (enable) begin
            s1_valid_r <= valid_in;
            s1_num_r   <= num_entrada;
        end
    end

    // Classify the operand and form the LUT address / bypass word.
    always_comb begin
        sign_s   = s1_num_r[31];
        exp_s    = s1_num_r[30:23];
        man_s    = s1_num_r[22:0];
        cls_s    = CLS_LUT;
        bypass_s = 16'h0000;
        // Implicit one plus the top mantissa bits, scaled down by the exponent
        // deficit; only meaningful for the LUT class.
        addr_s   = {1'b1, man_s[22 -: (ADDR_WIDTH - 1)]} >> (LUT_TOP_EXP - exp_s);
        if ((exp_s == 8'hFF) && (man_s != 23'h0)) begin
            cls_s    = CLS_NAN;
            bypass_s = BF16_QNAN;
        end else if (exp_s >= ONE_EXP) begin
            cls_s    = CLS_SAT;
            bypass_s = {sign_s, BF16_INF[14:0]};
        end else if (exp_s < LUT_MIN_EXP) begin
            // atanh(x) ~= x here; denormals and zero flush to signed zero.
            cls_s    = CLS_TINY;
            bypass_s = (exp_s == 8'h00) ? {sign_s, 15'h0000} : {sign_s, exp_s, man_s[22:16]};
        end else begin
            cls_s    = CLS_LUT;
            bypass_s = 16'h0000;
        end
    end

    memoria_single_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FRAC_BITS  (LUT_FRAC)
    ) u_lut (
        .clk    (clk),
        .enable (enable),
        .addr   (addr_s),
        .q      (lut_q_s)
    );

    // S2: class flags and bypass word travel alongside the LUT read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r  <= 1'b0;
            s2_sign_r   <= 1'b0;
            s2_cls_r    <= CLS_NAN;
            s2_bypass_r <= 16'h0000;
        end else if (enable) begin
            s2_valid_r  <= s1_valid_r;
            s2_sign_r   <= sign_s;
            s2_cls_r    <= cls_s;
            s2_bypass_r <= bypass_s;
        end
    end

    fixed_to_bf16 #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (LUT_FRAC)
    ) u_cvt (
        .q   (lut_q_s),
        .mag (mag_s)
    );

    // Select converted LUT value or the pre-formed special-case word.
    always_comb begin
        case (s2_cls_r)
            CLS_LUT: result_s = {s2_sign_r, mag_s};
            default: result_s = s2_bypass_r;
        endcase
    end

    // S3: register the selected result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid_r  <= 1'b0;
            s3_result_r <= 16'h0000;
        end else if (enable) begin
            s3_valid_r  <= s2_valid_r;
            s3_result_r <= result_s;
        end
    end

    // S4: output register; data only moves when a real result arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out_r  <= 1'b0;
            num_salida_r <= 16'h0000;
        end else if (enable) begin
            valid_out_r <= s3_valid_r;
            if (s3_valid_r) begin
                num_salida_r <= s3_result_r;
            end
        end
    end

    assign valid_out  = valid_out_r;
    assign num_salida = num_salida_r;

endmodule

// File: tb/tb_top_atanh_f2fp16.sv
// ----------------------------------------------------------------------------
// tb_top_atanh_f2fp16
//   Directed vectors with hand-computed results, streamed through the DUT;
//   a 4-deep expected-result queue lines each output slot up with the input
//   accepted three edges earlier. Extra sequences cover bubbles, stalls and
//   an asynchronous reset with samples in flight.
// ----------------------------------------------------------------------------
module tb_top_atanh_f2fp16;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        valid_in;
    logic [31:0] num_entrada;
    logic        valid_out;
    logic [15:0] num_salida;

    int total;
    int bad;

    typedef struct {
        logic [31:0] din;
        logic [15:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic        v;
        logic [15:0] d;
        string       name;
    } slot_t;

    localparam int NVEC = 18;
    vec_t  tbl [NVEC];
    slot_t exp_q [$];

    top_atanh_f2fp16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .valid_in    (valid_in),
        .num_entrada (num_entrada),
        .valid_out   (valid_out),
        .num_salida  (num_salida)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // One clock: drive inputs, take the edge, check the output slot.
    task automatic step(input logic vin, input logic [31:0] din, input logic [15:0] exp_v,
                        input string nm, input logic en);
        logic        pv;
        logic [15:0] pd;
        slot_t       s;
        valid_in    = vin;
        num_entrada = din;
        enable      = en;
        pv = valid_out;
        pd = num_salida;
        @(posedge clk);
        #1;
        if (en) begin
            s.v = vin;
            s.d = exp_v;
            s.name = nm;
            exp_q.push_back(s);
            if (exp_q.size() == 4) begin
                s = exp_q.pop_front();
                chk({s.name, "_valid"}, {31'd0, valid_out}, {31'd0, s.v});
                if (s.v) begin
                    chk(s.name, {16'd0, num_salida}, {16'd0, s.d});
                end
            end else begin
                chk("fill_valid", {31'd0, valid_out}, 32'd0);
            end
        end else begin
            chk("stall_valid", {31'd0, valid_out}, {31'd0, pv});
            chk("stall_data", {16'd0, num_salida}, {16'd0, pd});
        end
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 32'hDEAD_BEEF, 16'h0000, "bubble", 1'b1);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        tbl[0]  = '{32'h3F00_0000, 16'h3F0C, "half"};
        tbl[1]  = '{32'hBF00_0000, 16'hBF0C, "neg_half"};
        tbl[2]  = '{32'h3F80_0000, 16'h7F80, "one"};
        tbl[3]  = '{32'hFF80_0000, 16'hFF80, "neg_inf"};
        tbl[4]  = '{32'h7FC0_0000, 16'h7FC0, "nan"};
        tbl[5]  = '{32'h3980_0000, 16'h3980, "tiny_2m12"};
        tbl[6]  = '{32'h0000_0001, 16'h0000, "denorm"};
        tbl[7]  = '{32'h3E80_0000, 16'h3E83, "quarter"};
        tbl[8]  = '{32'h3F40_0000, 16'h3F79, "three_q"};
        tbl[9]  = '{32'h3EC0_0000, 16'h3ECA, "p375"};
        tbl[10] = '{32'h3A80_0000, 16'h3A80, "lut_min"};
        tbl[11] = '{32'h3A7F_FFFF, 16'h3A7F, "tiny_max"};
        tbl[12] = '{32'h3F7F_FFFF, 16'h4074, "lut_max"};
        tbl[13] = '{32'hBF7F_FFFF, 16'hC074, "neg_lut_max"};
        tbl[14] = '{32'hFFC0_0001, 16'h7FC0, "neg_nan"};
        tbl[15] = '{32'h8000_0000, 16'h8000, "neg_zero"};
        tbl[16] = '{32'h4000_0000, 16'h7F80, "two"};
        tbl[17] = '{32'h7F80_0000, 16'h7F80, "pos_inf"};

        // Reset state.
        rst_n       = 1'b0;
        enable      = 1'b1;
        valid_in    = 1'b1;
        num_entrada = 32'h3F00_0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_num_salida", {16'd0, num_salida}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single sample: latency check through the fill phase.
        step(1'b1, tbl[0].din, tbl[0].exp, "lat_half", 1'b1);
        bubble(4);

        // Whole table back-to-back.
        for (int i = 0; i < NVEC; i++) begin
            step(1'b1, tbl[i].din, tbl[i].exp, tbl[i].name, 1'b1);
        end
        bubble(3);

        // Alternating samples and bubbles.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, tbl[i + 7].din, tbl[i + 7].exp, {"alt_", tbl[i + 7].name}, 1'b1);
            step(1'b0, 32'h3F00_0000, 16'h0000, "alt_bubble", 1'b1);
        end
        bubble(3);

        // Stall for 3 cycles mid-stream; garbage on the inputs must be ignored.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, tbl[i].din, tbl[i].exp, {"stl_", tbl[i].name}, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h3F40_0000, 16'h0000, "stall", 1'b0);
        end
        for (int i = 5; i < 9; i++) begin
            step(1'b1, tbl[i].din, tbl[i].exp, {"stl_", tbl[i].name}, 1'b1);
        end
        bubble(3);

        // Async reset with samples in flight.
        for (int i = 7; i < 12; i++) begin
            step(1'b1, tbl[i].din, tbl[i].exp, {"pre_rst_", tbl[i].name}, 1'b1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, valid_out}, 32'd0);
        chk("async_rst_data", {16'd0, num_salida}, 32'd0);
        #2;
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'h3F00_0000, 16'h0000, "post_rst", 1'b1);
            chk("post_rst_valid", {31'd0, valid_out}, 32'd0);
        end

        // Pipeline still works after the reset.
        step(1'b1, tbl[8].din, tbl[8].exp, "after_rst_three_q", 1'b1);
        bubble(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
